// File: rtl/ex_mem_flag_if.sv
// ex_mem_flag_if: EX->MEM pipeline register bus (EX-side inputs, MEM-side outputs, flags, counter)
interface ex_mem_flag_if #(parameter int WIDTH = 16);
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic [WIDTH-1:0] ex_alu_result;
    logic             ex_alu_ovfl;
    logic [WIDTH-1:0] ex_store_data;
    logic [3:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_halt;
    logic             mem_valid;
    logic [WIDTH-1:0] mem_alu_result;
    logic [WIDTH-1:0] mem_store_data;
    logic [3:0]       mem_rd;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic             mem_halt;
    logic             flag_z;
    logic             flag_v;
    logic             flag_n;
    logic             flag_z_nxt;
    logic             flag_v_nxt;
    logic             flag_n_nxt;
    logic [15:0]      instr_count;

    modport master (
        output stall, flush, ex_valid, ex_opcode, ex_alu_result, ex_alu_ovfl, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt,
        input  mem_valid, mem_alu_result, mem_store_data, mem_rd, mem_reg_write, mem_mem_read,
               mem_mem_write, mem_halt, flag_z, flag_v, flag_n, flag_z_nxt, flag_v_nxt,
               flag_n_nxt, instr_count
    );

    modport slave (
        input  stall, flush, ex_valid, ex_opcode, ex_alu_result, ex_alu_ovfl, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt,
        output mem_valid, mem_alu_result, mem_store_data, mem_rd, mem_reg_write, mem_mem_read,
               mem_mem_write, mem_halt, flag_z, flag_v, flag_n, flag_z_nxt, flag_v_nxt,
               flag_n_nxt, instr_count
    );
endinterface

// File: rtl/ex_mem_flag_reg.sv
// ex_mem_flag_reg: EX->MEM pipeline register with Z/V/N flag register, flag forwarding and retire counter
module ex_mem_flag_reg #(
    parameter int WIDTH = 16
) (
    input logic          clk,
    input logic          rst,
    ex_mem_flag_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic             adv, hold, arith, zop;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] res_d, res_q, sd_d, sd_q;
    logic [3:0]       rd_d, rd_q, ctl_d, ctl_q;
    logic             z_d, z_q, v_d, v_q, n_d, n_q;
    logic [15:0]      cnt_d, cnt_q;

    // Next-state: flush beats stall; a stall without flush freezes everything; otherwise load or bubble
    always_comb begin
        adv     = bus.ex_valid & ~bus.stall & ~bus.flush;
        hold    = bus.stall & ~bus.flush;
        arith   = (bus.ex_opcode == OP_ADD) || (bus.ex_opcode == OP_SUB);
        zop     = arith || (bus.ex_opcode == OP_XOR) || (bus.ex_opcode == OP_SLL) ||
                  (bus.ex_opcode == OP_SRA) || (bus.ex_opcode == OP_ROR);
        z_d     = (adv && zop) ? (bus.ex_alu_result == '0) : z_q;
        v_d     = (adv && arith) ? bus.ex_alu_ovfl : v_q;
        n_d     = (adv && arith) ? bus.ex_alu_result[WIDTH-1] : n_q;
        valid_d = hold ? valid_q : adv;
        res_d   = hold ? res_q : (adv ? bus.ex_alu_result : '0);
        sd_d    = hold ? sd_q : (adv ? bus.ex_store_data : '0);
        rd_d    = hold ? rd_q : (adv ? bus.ex_rd : 4'd0);
        ctl_d   = hold ? ctl_q : (adv ? {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_halt} : 4'd0);
        cnt_d   = adv ? cnt_q + 16'd1 : cnt_q;
    end

    // State registers with synchronous reset clearing the in-flight MEM slot, flags and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            sd_q    <= '0;
            rd_q    <= 4'd0;
            ctl_q   <= 4'd0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            sd_q    <= sd_d;
            rd_q    <= rd_d;
            ctl_q   <= ctl_d;
            z_q     <= z_d;
            v_q     <= v_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_valid      = valid_q;
    assign bus.mem_alu_result = res_q;
    assign bus.mem_store_data = sd_q;
    assign bus.mem_rd         = rd_q;
    assign bus.mem_reg_write  = ctl_q[3];
    assign bus.mem_mem_read   = ctl_q[2];
    assign bus.mem_mem_write  = ctl_q[1];
    assign bus.mem_halt       = ctl_q[0];
    assign bus.flag_z         = z_q;
    assign bus.flag_v         = v_q;
    assign bus.flag_n         = n_q;
    assign bus.flag_z_nxt     = z_d;
    assign bus.flag_v_nxt     = v_d;
    assign bus.flag_n_nxt     = n_d;
    assign bus.instr_count    = cnt_q;
endmodule

// File: tb/tb_ex_mem_flag_reg.sv
// tb_ex_mem_flag_reg: scoreboard-driven bench for the EX->MEM register and flag logic
module tb_ex_mem_flag_reg;
    typedef struct packed {
        logic        valid;
        logic [15:0] res;
        logic [15:0] sd;
        logic [3:0]  rd;
        logic [3:0]  ctl;
        logic        z, v, n;
        logic [15:0] cnt;
    } st_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    st_t  m;
    st_t  sb[$];

    ex_mem_flag_if #(.WIDTH(16)) bus ();

    ex_mem_flag_reg #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic st_t dut_state();
        return {bus.mem_valid, bus.mem_alu_result, bus.mem_store_data, bus.mem_rd,
                bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write, bus.mem_halt,
                bus.flag_z, bus.flag_v, bus.flag_n, bus.instr_count};
    endfunction

    // One clock: drive inputs, check forwarded flags, push model prediction, clock, pop and compare
    task automatic step(input string nm, input logic r, input logic s, input logic f, input logic v,
                        input logic [3:0] op, input logic [15:0] res, input logic ov,
                        input logic [15:0] sd, input logic [3:0] rd, input logic [3:0] ctl,
                        input bit chk);
        logic adv, arith, zop;
        logic [2:0] nxt;
        st_t e, got;
        rst = r; bus.stall = s; bus.flush = f; bus.ex_valid = v; bus.ex_opcode = op;
        bus.ex_alu_result = res; bus.ex_alu_ovfl = ov; bus.ex_store_data = sd; bus.ex_rd = rd;
        {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_halt} = ctl;
        adv   = v & ~s & ~f;
        arith = (op == 4'd0) || (op == 4'd1);
        zop   = arith || (op == 4'd2) || (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
        nxt   = {m.z, m.v, m.n};
        if (adv && zop) nxt[2] = (res == 16'h0);
        if (adv && arith) nxt[1:0] = {ov, res[15]};
        e = m;
        if (r) e = '0;
        else if (f || (!s && !v)) begin
            e.valid = 0; e.res = 0; e.sd = 0; e.rd = 0; e.ctl = 0;
        end else if (!s) begin
            e = {1'b1, res, sd, rd, ctl, nxt, m.cnt + 16'd1};
        end
        sb.push_back(e);
        #1;
        if (chk) begin
            checks++;
            if ({bus.flag_z_nxt, bus.flag_v_nxt, bus.flag_n_nxt} !== nxt) begin
                errors++;
                $display("FAIL %s nxt: got zvn=%b expected %b", nm,
                         {bus.flag_z_nxt, bus.flag_v_nxt, bus.flag_n_nxt}, nxt);
            end
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        m = e;
        if (chk) begin
            got = dut_state();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s state: got v=%b res=%h sd=%h rd=%h ctl=%b zvn=%b%b%b cnt=%h expected v=%b res=%h sd=%h rd=%h ctl=%b zvn=%b%b%b cnt=%h",
                         nm, got.valid, got.res, got.sd, got.rd, got.ctl, got.z, got.v, got.n, got.cnt,
                         e.valid, e.res, e.sd, e.rd, e.ctl, e.z, e.v, e.n, e.cnt);
            end
        end
    endtask

    task automatic do_reset();
        step("reset", 1, 0, 0, 1, 4'd0, 16'h5555, 1, 16'h1111, 4'd3, 4'hF, 1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_state() !== st_t'(0)) begin
            errors++;
            $display("FAIL reset_zero: got %h expected 0", dut_state());
        end
    endtask

    task automatic test_add();
        rst = 0; bus.stall = 0; bus.flush = 0; bus.ex_valid = 1; bus.ex_opcode = 4'd0;
        bus.ex_alu_result = 16'h8000; bus.ex_alu_ovfl = 1;
        #1;
        checks++;
        if ({bus.flag_z_nxt, bus.flag_v_nxt, bus.flag_n_nxt} !== 3'b011) begin
            errors++;
            $display("FAIL add_nxt_const: got %b expected 011", {bus.flag_z_nxt, bus.flag_v_nxt, bus.flag_n_nxt});
        end
        step("add", 0, 0, 0, 1, 4'd0, 16'h8000, 1, 16'h00AA, 4'd5, 4'b1000, 1);
        checks++;
        if ({bus.mem_alu_result, bus.flag_z, bus.flag_v, bus.flag_n, bus.instr_count} !== {16'h8000, 3'b011, 16'd1}) begin
            errors++;
            $display("FAIL add_const: got res=%h zvn=%b%b%b cnt=%0d expected res=8000 zvn=011 cnt=1",
                     bus.mem_alu_result, bus.flag_z, bus.flag_v, bus.flag_n, bus.instr_count);
        end
    endtask

    task automatic test_paddsb_xor();
        step("paddsb", 0, 0, 0, 1, 4'd7, 16'h0000, 1, 16'h0, 4'd1, 4'b1000, 1);
        checks++;
        if ({bus.flag_z, bus.flag_v, bus.flag_n} !== 3'b011) begin
            errors++;
            $display("FAIL paddsb_hold: got %b expected 011", {bus.flag_z, bus.flag_v, bus.flag_n});
        end
        step("xor", 0, 0, 0, 1, 4'd2, 16'h0000, 0, 16'h0, 4'd2, 4'b1000, 1);
        checks++;
        if ({bus.flag_z, bus.flag_v, bus.flag_n, bus.mem_alu_result} !== {3'b111, 16'h0}) begin
            errors++;
            $display("FAIL xor_z: got zvn=%b%b%b res=%h expected 111 0000",
                     bus.flag_z, bus.flag_v, bus.flag_n, bus.mem_alu_result);
        end
    endtask

    task automatic test_stall();
        logic [15:0] c0;
        c0 = m.cnt;
        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 0, 1, 4'd1, 16'h1234, 0, 16'h0BEE, 4'd7, 4'b1000, 1);
        step("stall_rel", 0, 0, 0, 1, 4'd1, 16'h1234, 0, 16'h0BEE, 4'd7, 4'b1000, 1);
        checks++;
        if ({bus.mem_alu_result, bus.flag_z, bus.flag_v, bus.flag_n, bus.instr_count} !== {16'h1234, 3'b000, c0 + 16'd1}) begin
            errors++;
            $display("FAIL stall_release: got res=%h zvn=%b%b%b cnt=%h expected 1234 000 cnt=%h",
                     bus.mem_alu_result, bus.flag_z, bus.flag_v, bus.flag_n, bus.instr_count, c0 + 16'd1);
        end
    endtask

    task automatic test_flush_stall();
        step("flush_stall", 0, 1, 1, 1, 4'd0, 16'h0000, 0, 16'h0, 4'd9, 4'b1000, 1);
        step("flush_only", 0, 0, 1, 1, 4'd2, 16'h0000, 0, 16'h0, 4'd9, 4'b1001, 1);
        step("bubble", 0, 0, 0, 0, 4'd0, 16'h0000, 1, 16'h7, 4'd4, 4'b1111, 1);
    endtask

    task automatic test_back_to_back();
        step("b2b_sub", 0, 0, 0, 1, 4'd1, 16'hFFF0, 0, 16'h0, 4'd1, 4'b1000, 1);
        step("b2b_sll", 0, 0, 0, 1, 4'd4, 16'h0000, 1, 16'h0, 4'd2, 4'b1000, 1);
        step("b2b_add", 0, 0, 0, 1, 4'd0, 16'h7FFF, 1, 16'h0, 4'd3, 4'b1000, 1);
        step("b2b_ror", 0, 0, 0, 1, 4'd6, 16'h0001, 0, 16'h0, 4'd4, 4'b1000, 1);
        step("b2b_lw", 0, 0, 0, 1, 4'd8, 16'h0000, 1, 16'h0, 4'd5, 4'b1100, 1);
        step("b2b_hlt", 0, 0, 0, 1, 4'd15, 16'h0000, 0, 16'h0, 4'd0, 4'b0001, 1);
        step("b2b_sra", 0, 0, 0, 1, 4'd5, 16'h0000, 0, 16'h0, 4'd6, 4'b1000, 1);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 65535; i++)
            step("wrap_fill", 0, 0, 0, 1, 4'd10, 16'h0042, 0, 16'h0, 4'd1, 4'b1000, 0);
        checks++;
        if (bus.instr_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_ffff: got %h expected ffff", bus.instr_count);
        end
        step("wrap", 0, 0, 0, 1, 4'd10, 16'h0042, 0, 16'h0, 4'd1, 4'b1000, 1);
        checks++;
        if (bus.instr_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: got %h expected 0000", bus.instr_count);
        end
    endtask

    task automatic test_reset_mid();
        step("mid_xor", 0, 0, 0, 1, 4'd2, 16'h0000, 0, 16'h0, 4'd1, 4'b1000, 1);
        step("mid_sw", 0, 0, 0, 1, 4'd9, 16'h0010, 0, 16'hCAFE, 4'd0, 4'b0010, 1);
        checks++;
        if ({bus.mem_valid, bus.mem_mem_write, bus.flag_z} !== 3'b111) begin
            errors++;
            $display("FAIL mid_sw_setup: got %b expected 111", {bus.mem_valid, bus.mem_mem_write, bus.flag_z});
        end
        test_reset();
        step("post_rst", 0, 0, 0, 1, 4'd11, 16'h3300, 0, 16'h0, 4'd2, 4'b1000, 1);
        checks++;
        if (bus.instr_count !== 16'd1) begin
            errors++;
            $display("FAIL post_rst_cnt: got %0d expected 1", bus.instr_count);
        end
    endtask

    initial begin
        m = '0;
        rst = 1; bus.stall = 0; bus.flush = 0; bus.ex_valid = 0; bus.ex_opcode = 0;
        bus.ex_alu_result = 0; bus.ex_alu_ovfl = 0; bus.ex_store_data = 0; bus.ex_rd = 0;
        bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_mem_write = 0; bus.ex_halt = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_paddsb_xor();
        test_stall();
        test_flush_stall();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
